// File: rtl/motor_curr_if.sv
// motor_curr_if
//  Assist-current interface between the torque path (master) and the PI
//  current regulator (slave).
//  Signals:
//   target_curr  [11:0] desired motor current, unsigned
//   avg_curr     [11:0] averaged measured motor current, unsigned
//   curr_rdy            1-cycle strobe, avg_curr holds a new sample
//   not_pedaling        rider not pedaling, forces zero drive
//   drv_mag      [11:0] drive magnitude to PWM, unsigned
//   drv_vld             1-cycle pulse, drv_mag just updated
interface motor_curr_if;
  logic [11:0] target_curr;
  logic [11:0] avg_curr;
  logic        curr_rdy;
  logic        not_pedaling;
  logic [11:0] drv_mag;
  logic        drv_vld;

  modport master (
    output target_curr, avg_curr, curr_rdy, not_pedaling,
    input  drv_mag, drv_vld
  );

  modport slave (
    input  target_curr, avg_curr, curr_rdy, not_pedaling,
    output drv_mag, drv_vld
  );
endinterface

// File: rtl/motor_curr_ctrl.sv
// motor_curr_ctrl
//  PI current regulator. Each curr_rdy strobe launches one sample through a
//  3-stage pipeline:
//   stage 1  saturated error target_curr - avg_curr
//   stage 2  integrator update (clear, anti-windup hold, or clamped add)
//   stage 3  proportional + integral/2^I_SHIFT, clamped to 12 bits
//  Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   motor_curr_if.slave (target_curr, avg_curr, curr_rdy,
//         not_pedaling in; drv_mag, drv_vld out)
module motor_curr_ctrl #(
  parameter int INTEG_W = 18,
  parameter int I_SHIFT = 5
) (
  input  logic         clk,
  input  logic         rst,
  motor_curr_if.slave  bus
);

  localparam int SUM_W = INTEG_W + 2;
  localparam logic [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};

  // Signed 13-bit difference clamped into the signed 12-bit range.
  function automatic logic signed [11:0] sat_err(input logic [11:0] tgt,
                                                 input logic [11:0] avg);
    logic signed [12:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, avg});
    if (diff > 13'sd2047) begin
      return 12'sh7FF;
    end else if (diff < -13'sd2048) begin
      return 12'sh800;
    end else begin
      return diff[11:0];
    end
  endfunction

  // Clamp a wide signed value into [0, INTEG_MAX].
  function automatic logic [INTEG_W-1:0] clamp_integ(input logic signed [SUM_W-1:0] v);
    if (v < $signed({SUM_W{1'b0}})) begin
      return {INTEG_W{1'b0}};
    end else if (v > $signed({2'b00, INTEG_MAX})) begin
      return INTEG_MAX;
    end else begin
      return v[INTEG_W-1:0];
    end
  endfunction

  // Clamp a wide signed value into the unsigned 12-bit drive range.
  function automatic logic [11:0] clamp_drv(input logic signed [SUM_W-1:0] v);
    if (v < $signed({SUM_W{1'b0}})) begin
      return 12'h000;
    end else if (v > $signed({{(SUM_W-12){1'b0}}, 12'hFFF})) begin
      return 12'hFFF;
    end else begin
      return v[11:0];
    end
  endfunction

  logic signed [11:0]  err_r;
  logic signed [11:0]  err_d_r;
  logic                v1_r;
  logic                v2_r;
  logic [INTEG_W-1:0]  integ_r;
  logic [11:0]         drv_mag_r;
  logic                drv_vld_r;

  logic [INTEG_W-1:0]  integ_nxt_s;
  logic [11:0]         drv_nxt_s;
  logic signed [SUM_W-1:0] integ_sum_s;
  logic signed [SUM_W-1:0] drv_sum_s;
  logic                err_pos_s;

  // Next integrator value and next drive magnitude.
  always_comb begin
    integ_nxt_s = integ_r;
    drv_nxt_s   = drv_mag_r;
    err_pos_s   = (err_r[11] == 1'b0) && (err_r != 12'sd0);
    integ_sum_s = $signed({2'b00, integ_r}) +
                  $signed({{(SUM_W-12){err_r[11]}}, err_r});
    // integ_r already carries this sample's stage-2 update when stage 3 runs.
    drv_sum_s   = $signed({{(SUM_W-12){err_d_r[11]}}, err_d_r}) +
                  $signed({2'b00, (integ_r >> I_SHIFT)});

    if (v1_r) begin
      if (bus.not_pedaling) begin
        integ_nxt_s = {INTEG_W{1'b0}};
      end else if (err_pos_s && (drv_mag_r == 12'hFFF)) begin
        // Output already pinned high: stop accumulating positive error.
        integ_nxt_s = integ_r;
      end else begin
        integ_nxt_s = clamp_integ(integ_sum_s);
      end
    end else begin
      integ_nxt_s = integ_r;
    end

    if (v2_r) begin
      if (bus.not_pedaling) begin
        drv_nxt_s = 12'h000;
      end else begin
        drv_nxt_s = clamp_drv(drv_sum_s);
      end
    end else begin
      drv_nxt_s = drv_mag_r;
    end
  end

  // Pipeline registers, integrator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r     <= 12'sd0;
      err_d_r   <= 12'sd0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      integ_r   <= {INTEG_W{1'b0}};
      drv_mag_r <= 12'h000;
      drv_vld_r <= 1'b0;
    end else begin
      v1_r      <= bus.curr_rdy;
      v2_r      <= v1_r;
      drv_vld_r <= v2_r;
      if (bus.curr_rdy) begin
        err_r <= sat_err(bus.target_curr, bus.avg_curr);
      end
      if (v1_r) begin
        err_d_r <= err_r;
      end
      integ_r   <= integ_nxt_s;
      drv_mag_r <= drv_nxt_s;
    end
  end

  assign bus.drv_mag = drv_mag_r;
  assign bus.drv_vld = drv_vld_r;

endmodule

// File: tb/tb_motor_curr_ctrl.sv
// tb_motor_curr_ctrl
//  Directed bench for motor_curr_ctrl. Inputs change on the falling edge,
//  outputs are sampled on the falling edge, half a cycle after the rising
//  edge that updates them. Expected values are hand computed.
module tb_motor_curr_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   vld_cnt;

  motor_curr_if bus_if ();

  motor_curr_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [11:0] tgt, input logic [11:0] avg);
    bus_if.target_curr = tgt;
    bus_if.avg_curr    = avg;
    bus_if.curr_rdy    = 1'b1;
    @(negedge clk);
    bus_if.curr_rdy    = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    vld_cnt = 0;
    rst = 1'b1;
    bus_if.target_curr  = 12'($urandom);
    bus_if.avg_curr     = 12'($urandom);
    bus_if.curr_rdy     = 1'($urandom);
    bus_if.not_pedaling = 1'b0;

    // 1: reset with random inputs, then idle with random data but no strobe
    repeat (3) @(negedge clk);
    chk("rst_mag", 32'(bus_if.drv_mag), 32'd0);
    chk("rst_vld", 32'(bus_if.drv_vld), 32'd0);
    rst = 1'b0;
    bus_if.curr_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_if.target_curr = 12'($urandom);
      bus_if.avg_curr    = 12'($urandom);
      @(negedge clk);
      if (bus_if.drv_vld !== 1'b0) vld_cnt++;
    end
    chk("idle_vld_cnt", 32'(vld_cnt), 32'd0);
    chk("idle_mag", 32'(bus_if.drv_mag), 32'd0);

    // 2: single sample, inputs changed after capture must not matter
    strobe(12'h400, 12'h300);
    bus_if.target_curr = 12'h000;
    bus_if.avg_curr    = 12'hFFF;
    chk("t2_vld_e1", 32'(bus_if.drv_vld), 32'd0);
    @(negedge clk);
    chk("t2_vld_e2", 32'(bus_if.drv_vld), 32'd0);
    @(negedge clk);
    chk("t2_vld_e3", 32'(bus_if.drv_vld), 32'd1);
    chk("t2_mag", 32'(bus_if.drv_mag), 32'h108);
    chk("t2_integ", 32'(dut.integ_r), 32'd256);
    @(negedge clk);
    chk("t2_vld_drop", 32'(bus_if.drv_vld), 32'd0);
    chk("t2_mag_hold", 32'(bus_if.drv_mag), 32'h108);

    // 3: deep negative error, 50 back-to-back strobes
    vld_cnt = 0;
    bus_if.target_curr = 12'h000;
    bus_if.avg_curr    = 12'hFFF;
    bus_if.curr_rdy    = 1'b1;
    for (int i = 0; i < 54; i++) begin
      @(negedge clk);
      if (i == 49) bus_if.curr_rdy = 1'b0;
      if (bus_if.drv_vld === 1'b1) begin
        vld_cnt++;
        chk("t3_mag_zero", 32'(bus_if.drv_mag), 32'd0);
      end
    end
    chk("t3_vld_cnt", 32'(vld_cnt), 32'd50);
    chk("t3_err_clamp", 32'(dut.err_d_r), 32'hFFFFF800);
    chk("t3_integ", 32'(dut.integ_r), 32'd0);

    // 4: max positive error every cycle, saturation and anti-windup
    vld_cnt = 0;
    bus_if.target_curr = 12'hFFF;
    bus_if.avg_curr    = 12'h000;
    bus_if.curr_rdy    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 59) bus_if.curr_rdy = 1'b0;
      if (bus_if.drv_vld === 1'b1) vld_cnt++;
    end
    chk("t4_vld_cnt", 32'(vld_cnt), 32'd60);
    chk("t4_mag_sat", 32'(bus_if.drv_mag), 32'hFFF);
    // 2047 per sample; samples 0..33 integrate, hold from sample 34 on
    chk("t4_integ_hold", 32'(dut.integ_r), 32'd69598);
    chk("t4_integ_bound", 32'(dut.integ_r <= 18'd131071), 32'd1);

    // 5: not_pedaling clears integrator and forces zero drive
    bus_if.not_pedaling = 1'b1;
    strobe(12'hFFF, 12'h000);
    @(negedge clk);
    @(negedge clk);
    chk("t5_np_vld", 32'(bus_if.drv_vld), 32'd1);
    chk("t5_np_mag", 32'(bus_if.drv_mag), 32'd0);
    chk("t5_np_integ", 32'(dut.integ_r), 32'd0);
    bus_if.not_pedaling = 1'b0;
    strobe(12'h400, 12'h300);
    @(negedge clk);
    @(negedge clk);
    chk("t5_resume_vld", 32'(bus_if.drv_vld), 32'd1);
    chk("t5_resume_mag", 32'(bus_if.drv_mag), 32'h108);

    // 6: reset right after a capture discards the sample
    strobe(12'h800, 12'h100);
    rst = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (bus_if.drv_vld !== 1'b0) vld_cnt++;
    end
    chk("t6_no_vld", 32'(vld_cnt), 32'd0);
    chk("t6_mag_zero", 32'(bus_if.drv_mag), 32'd0);
    strobe(12'h400, 12'h300);
    chk("t6_vld_e1", 32'(bus_if.drv_vld), 32'd0);
    @(negedge clk);
    chk("t6_vld_e2", 32'(bus_if.drv_vld), 32'd0);
    @(negedge clk);
    chk("t6_vld_e3", 32'(bus_if.drv_vld), 32'd1);
    chk("t6_mag", 32'(bus_if.drv_mag), 32'h108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
